// File: rtl/risc8_fetch.sv
// risc8 instruction fetch/prefetch stage: streams ROM bytes into a small byte
// queue and presents one complete instruction (opcode + immediates) per handshake.
module risc8_fetch #(
  parameter int unsigned           ADDR_W    = 16,
  parameter int unsigned           DEPTH     = 4,
  parameter logic [ADDR_W-1:0]     RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              redir,
  input  logic [ADDR_W-1:0] redir_addr,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [7:0]        ins_op,
  output logic [15:0]       ins_imm,
  output logic [1:0]        ins_size,
  output logic [ADDR_W-1:0] ins_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Instruction length minus one, decoded from the opcode byte.
  function automatic logic [1:0] op_size(input logic [7:0] op);
    logic [1:0] sz;
    sz = 2'd0;
    if (op == 8'hF0 || op == 8'hF2)
      sz = 2'd2;
    else if (op inside {8'h00, 8'h05, 8'h0A, 8'h0F, 8'hFC, 8'hFD} || op[7:4] == 4'h8)
      sz = 2'd1;
    return sz;
  endfunction

  logic [7:0]        q_data   [DEPTH];
  logic [ADDR_W-1:0] q_addr   [DEPTH];
  logic [7:0]        q_data_n [DEPTH];
  logic [ADDR_W-1:0] q_addr_n [DEPTH];
  logic [CNT_W-1:0]  count, count_n;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_q;

  logic [1:0]        head_size;
  logic [CNT_W-1:0]  head_len;
  logic [CNT_W-1:0]  pop_n;
  logic [CNT_W:0]    occupancy;
  logic              push;

  assign head_size = op_size(q_data[0]);
  assign head_len  = CNT_W'({1'b0, head_size}) + CNT_W'(1);
  assign ins_valid = (count >= head_len);

  // Space is judged from registered state only, so same-cycle pops free nothing.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(rd_q);
  assign rom_rd    = rst_n & ~redir & (occupancy < (CNT_W+1)'(DEPTH));
  assign rom_addr  = fetch_addr;

  assign pop_n = (ins_valid && ins_ready && !redir) ? head_len : '0;
  assign push  = rd_q & ~redir;

  assign ins_op   = q_data[0];
  assign ins_pc   = q_addr[0];
  assign ins_size = ins_valid ? head_size : 2'd0;
  assign ins_imm  = ins_valid ? {(head_size == 2'd2) ? q_data[2] : 8'h00,
                                 (head_size != 2'd0) ? q_data[1] : 8'h00} : 16'h0000;

  // Queue update: shift out popped bytes, append the returning byte at the new tail.
  always_comb begin
    int src;
    int wr;
    for (int i = 0; i < int'(DEPTH); i++) begin
      q_data_n[i] = 8'h00;
      q_addr_n[i] = '0;
    end
    count_n = count;
    for (int i = 0; i < int'(DEPTH); i++) begin
      src = i + int'(pop_n);
      if (src < int'(DEPTH)) begin
        q_data_n[i] = q_data[src];
        q_addr_n[i] = q_addr[src];
      end
    end
    wr = int'(count) - int'(pop_n);
    if (push && wr >= 0 && wr < int'(DEPTH)) begin
      q_data_n[wr] = rom_data;
      q_addr_n[wr] = rd_addr_q;
    end
    count_n = count - pop_n + CNT_W'(push);
    if (redir)
      count_n = '0;
  end

  // Queue, fetch pointer and in-flight read tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= 8'h00;
        q_addr[i] <= (i == 0) ? RESET_VEC : '0;
      end
      count      <= '0;
      fetch_addr <= RESET_VEC;
      rd_addr_q  <= RESET_VEC;
      rd_q       <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= q_data_n[i];
        q_addr[i] <= q_addr_n[i];
      end
      count <= count_n;
      rd_q  <= rom_rd;
      if (rom_rd)
        rd_addr_q <= fetch_addr;
      if (redir)
        fetch_addr <= redir_addr;
      else if (rom_rd)
        fetch_addr <= fetch_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_risc8_fetch.sv
// Self-checking bench for risc8_fetch: ROM responder plus an instruction-stream
// reference model derived from the opcode length table and fetch-space rules.
module tb_risc8_fetch;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        redir;
  logic [15:0] redir_addr;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_op;
  logic [15:0] ins_imm;
  logic [1:0]  ins_size;
  logic [15:0] ins_pc;

  risc8_fetch #(.ADDR_W(16), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .redir(redir), .redir_addr(redir_addr),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_op(ins_op), .ins_imm(ins_imm), .ins_size(ins_size), .ins_pc(ins_pc)
  );

  logic [7:0] rom [0:65535];

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes claimed (issued, not yet consumed), reads issued
  // last cycle, next fetch address, and address of the next instruction.
  int          occ;
  int          issued_prev;
  logic [15:0] m_fetch;
  logic [15:0] m_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= rom_rd ? rom[rom_addr] : 8'h00;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int mlen(input logic [7:0] op);
    if (op == 8'hF0 || op == 8'hF2) return 3;
    if (op == 8'h00 || op == 8'h05 || op == 8'h0A || op == 8'h0F ||
        op == 8'hFC || op == 8'hFD || (op >= 8'h80 && op <= 8'h8F)) return 2;
    return 1;
  endfunction

  function automatic logic mvalid();
    return (occ - issued_prev) >= mlen(rom[m_pc]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic tick(input logic r, input logic [15:0] ra, input logic rdy);
    logic        exp_rd;
    logic        exp_valid;
    logic        acc;
    int          len;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] eimm;
    @(negedge clk);
    redir = r;
    redir_addr = ra;
    ins_ready = rdy;
    #1;
    exp_rd = !r && (occ < DEPTH);
    chk("rom_rd", 32'(rom_rd), 32'(exp_rd));
    if (exp_rd) chk("rom_addr", 32'(rom_addr), 32'(m_fetch));
    len = mlen(rom[m_pc]);
    exp_valid = (occ - issued_prev) >= len;
    chk("ins_valid", 32'(ins_valid), 32'(exp_valid));
    if (exp_valid) begin
      a1 = m_pc + 16'd1;
      a2 = m_pc + 16'd2;
      eimm = {(len == 3) ? rom[a2] : 8'h00, (len >= 2) ? rom[a1] : 8'h00};
      chk("ins_op", 32'(ins_op), 32'(rom[m_pc]));
      chk("ins_imm", 32'(ins_imm), 32'(eimm));
      chk("ins_size", 32'(ins_size), 32'(len - 1));
      chk("ins_pc", 32'(ins_pc), 32'(m_pc));
    end
    acc = exp_valid && rdy;
    if (r) begin
      occ = 0;
      issued_prev = 0;
      m_fetch = ra;
      m_pc = ra;
    end else begin
      occ = occ + (exp_rd ? 1 : 0) - (acc ? len : 0);
      issued_prev = exp_rd ? 1 : 0;
      if (exp_rd) m_fetch = m_fetch + 16'd1;
      if (acc) m_pc = m_pc + 16'(len);
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redir = 1'b0;
    #1;
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_op", 32'(ins_op), 32'd0);
    chk("rst_imm", 32'(ins_imm), 32'd0);
    chk("rst_size", 32'(ins_size), 32'd0);
    chk("rst_pc", 32'(ins_pc), 32'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    occ = 0;
    issued_prev = 0;
    m_fetch = 16'h0000;
    m_pc = 16'h0000;
  endtask

  initial begin
    int   guard;
    logic [7:0] mb [0:5];
    rst_n = 1'b0;
    redir = 1'b0;
    redir_addr = 16'h0000;
    ins_ready = 1'b0;
    mb[0] = 8'hF0; mb[1] = 8'hF2; mb[2] = 8'h05; mb[3] = 8'h84; mb[4] = 8'hFC; mb[5] = 8'h0F;
    for (int i = 0; i < 65536; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? mb[$urandom_range(0, 5)] : 8'($urandom);

    // Two 1-byte opcodes accepted on consecutive cycles.
    rom[0] = 8'h10; rom[1] = 8'hB0; rom[2] = 8'h20; rom[3] = 8'h30;
    do_reset();
    repeat (8) tick(1'b0, 16'h0, 1'b1);

    // 2-byte CPY1 followed by its successor.
    rom[0] = 8'h05; rom[1] = 8'h7E; rom[2] = 8'h11;
    do_reset();
    repeat (6) tick(1'b0, 16'h0, 1'b1);

    // CALL stalled by decode: outputs hold, fetch stops when the queue is claimed.
    rom[0] = 8'hF0; rom[1] = 8'h34; rom[2] = 8'h12; rom[3] = 8'h40;
    do_reset();
    repeat (3) tick(1'b0, 16'h0, 1'b0);
    repeat (5) tick(1'b0, 16'h0, 1'b0);
    repeat (4) tick(1'b0, 16'h0, 1'b1);

    // Redirect while the read of 0x0007 is in flight.
    for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
    rom[16'h0200] = 8'h21; rom[16'h0201] = 8'h22;
    do_reset();
    guard = 0;
    while (!(m_fetch == 16'h0007 && occ < DEPTH) && guard < 50) begin
      tick(1'b0, 16'h0, 1'b1);
      guard++;
    end
    chk("reach_0007", 32'(guard < 50), 32'd1);
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b1, 16'h0200, 1'b1);
    repeat (6) tick(1'b0, 16'h0, 1'b1);

    // Redirect coincident with an accepted instruction.
    rom[16'h0300] = 8'h05; rom[16'h0301] = 8'h99; rom[16'h0302] = 8'h33;
    guard = 0;
    while (!mvalid() && guard < 20) begin
      tick(1'b0, 16'h0, 1'b0);
      guard++;
    end
    chk("reach_valid", 32'(guard < 20), 32'd1);
    tick(1'b1, 16'h0300, 1'b1);
    repeat (6) tick(1'b0, 16'h0, 1'b1);

    // JUMP spanning the address wrap; back-to-back redirects, last one wins.
    rom[16'hFFFF] = 8'hF2; rom[16'h0000] = 8'hAA; rom[16'h0001] = 8'h55; rom[16'h0002] = 8'h10;
    tick(1'b1, 16'h1234, 1'b1);
    tick(1'b1, 16'hFFFF, 1'b1);
    repeat (8) tick(1'b0, 16'h0, 1'b0);
    repeat (6) tick(1'b0, 16'h0, 1'b1);

    // Randomized traffic with sporadic redirects and mid-run resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 599) == 0)
        do_reset();
      else if ($urandom_range(0, 99) < 3)
        tick(1'b1, 16'($urandom), ($urandom_range(0, 3) != 0));
      else
        tick(1'b0, 16'h0, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
